uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single `uart_tx` transmitter between `N_REQ` byte-producing requesters. It latches one byte per grant, issues a one-cycle `send` to the transmitter, then waits for the frame-complete pulse before granting again. A watchdog recovers if the transmitter never reports completion. The block sits directly in front of `uart_tx`, with `tx_send`/`tx_data` wired to its `send`/`data` and its `tx_done` wired back in.

---
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between N_REQ byte producers
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TIMEOUT  = 4096,
  parameter int IDLE_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  input  logic                     tx_done
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + IDLE_GAP + 1);
  typedef enum logic [1:0] {ARB, SEND, WAIT, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [OW-1:0] last, last_n, owner_n, sel;
  logic [N_REQ-1:0] gnt_n;
  logic [7:0] data_n;
  logic send_n, tmo_n, hit;
  // pick the first requester after the last granted one, wrapping around
  always_comb begin
    sel = last;
    hit = 1'b0;
    for (int k = 1; k <= N_REQ; k++)
      if (!hit && req[(int'(last) + k) % N_REQ]) begin
        sel = OW'((int'(last) + k) % N_REQ);
        hit = 1'b1;
      end
  end
  // next-state and next registered outputs; one counter serves both watchdog and idle gap
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt_n   = '0;
    send_n  = 1'b0;
    tmo_n   = 1'b0;
    data_n  = tx_data;
    owner_n = owner;
    last_n  = last;
    case (state)
      ARB: if (hit) begin
        data_n  = req_data[8*sel +: 8];
        owner_n = sel;
        last_n  = sel;
        gnt_n   = N_REQ'(1) << sel;
        send_n  = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        if (tx_done) begin
          cnt_n   = '0;
          state_n = IDLE_GAP == 0 ? ARB : GAP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_n   = 1'b1;
          state_n = ARB;
        end
      end
      default: begin
        cnt_n   = cnt + CW'(1);
        state_n = cnt + CW'(1) >= CW'(IDLE_GAP) ? ARB : GAP;
      end
    endcase
  end
  // state and output registers; reset makes requester 0 the first in line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= ARB;
      cnt     <= '0;
      gnt     <= '0;
      tx_send <= 1'b0;
      timeout <= 1'b0;
      tx_data <= '0;
      owner   <= '0;
      last    <= OW'(N_REQ - 1);
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      tx_send <= send_n;
      timeout <= tmo_n;
      tx_data <= data_n;
      owner   <= owner_n;
      last    <= last_n;
      busy    <= state_n != ARB;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench with a 2-clock/bit serializer model
module tb_uart_tx_arbiter;
  typedef struct {int idx; logic [7:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0, wd_req = '0;
  logic [31:0] req_data = 32'h13A51110;
  logic [3:0] gnt, wd_gnt;
  logic [1:0] owner, wd_owner;
  logic busy, timeout, tx_send, wd_busy, wd_timeout, wd_tx_send;
  logic [7:0] tx_data, wd_tx_data;
  logic tx_done, wd_done = 1'b0;
  logic m_on, m_done, tx;
  logic [4:0] m_pc;
  logic [9:0] m_sh;
  logic rx_on;
  int rx_k;
  logic [7:0] rx_b;
  exp_t exp_q[$];
  logic [7:0] ser_q[$], rx_q[$];
  int checks = 0, errors = 0;
  logic [9:0] bits;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(64), .IDLE_GAP(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .owner(owner),
    .busy(busy), .timeout(timeout), .tx_send(tx_send), .tx_data(tx_data), .tx_done(tx_done));
  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16), .IDLE_GAP(2)) dut_wd (
    .clk(clk), .rst(rst), .req(wd_req), .req_data(req_data), .gnt(wd_gnt), .owner(wd_owner),
    .busy(wd_busy), .timeout(wd_timeout), .tx_send(wd_tx_send), .tx_data(wd_tx_data), .tx_done(wd_done));

  always #5 clk = ~clk;

  // transmitter model: 10-bit frame at 2 clocks/bit, done pulse after the stop bit
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_on <= 1'b0; m_pc <= '0; m_sh <= '1; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_on) begin
        if (tx_send) begin m_on <= 1'b1; m_pc <= '0; m_sh <= {1'b1, tx_data, 1'b0}; end
      end else if (m_pc == 5'd19) begin
        m_on <= 1'b0; m_done <= 1'b1;
      end else begin
        m_pc <= m_pc + 5'd1;
        if (m_pc[0]) m_sh <= m_sh >> 1;
      end
    end
  assign tx = m_on ? m_sh[0] : 1'b1;
  assign tx_done = m_done;

  // serial receiver: samples the line mid-bit and collects bytes in order
  always @(negedge clk or posedge rst)
    if (rst) begin
      rx_on = 1'b0; rx_k = 0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin rx_on = 1'b1; rx_k = 0; end
    end else begin
      rx_k++;
      if (rx_k % 2 == 0 && rx_k >= 2 && rx_k <= 16) rx_b[rx_k/2-1] = tx;
      if (rx_k == 18) begin rx_on = 1'b0; rx_q.push_back(rx_b); end
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_gnt();
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (gnt === '0 && n < 60) begin @(negedge clk); n++; end
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 1);
      return;
    end
    e = exp_q.pop_front();
    chk("gnt", gnt, 32'(1) << e.idx);
    chk("owner", owner, e.idx);
    chk("tx_data", tx_data, e.data);
    chk("tx_send", tx_send, 1);
    chk("busy_grant", busy, 1);
  endtask

  task automatic drain();
    chk("rx_count", rx_q.size(), ser_q.size());
    while (rx_q.size() != 0 && ser_q.size() != 0) chk("rx_byte", rx_q.pop_front(), ser_q.pop_front());
    rx_q.delete();
    ser_q.delete();
  endtask

  initial begin
    tick(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_line", tx, 1);
    rst = 1'b0;
    tick(3);
    chk("idle_tx_send", tx_send, 0);
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    // single requester 2 with byte A5, then frame bits on the line
    req = 4'b0100;
    exp_q.push_back('{2, 8'hA5});
    ser_q.push_back(8'hA5);
    wait_gnt();
    req = '0;
    tick(1);
    chk("send_once", tx_send, 0);
    chk("gnt_once", gnt, 0);
    bits = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      chk("tx_bit", tx, bits[b]);
      tick(2);
    end
    tick(2);
    chk("gap_busy", busy, 1);
    tick(1);
    chk("gap_end_busy", busy, 0);
    // all four requesting: round-robin from requester 0 after reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req_data = 32'h13121110;
    req = 4'b1111;
    foreach (exp_q[i]) exp_q.delete(i);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{i % 4, 8'h10 + 8'(i % 4)});
      ser_q.push_back(8'h10 + 8'(i % 4));
    end
    for (int i = 0; i < 5; i++) wait_gnt();
    req = '0;
    tick(30);
    drain();
    // asynchronous reset in the middle of a frame
    req = 4'b1000;
    exp_q.push_back('{3, 8'h13});
    wait_gnt();
    req = '0;
    tick(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_owner", owner, 0);
    chk("arst_tx_line", tx, 1);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    exp_q.push_back('{1, 8'h11});
    ser_q.push_back(8'h11);
    wait_gnt();
    req = '0;
    tick(30);
    drain();
    // watchdog abort with tx_done held low, then next pending requester
    wd_req = 4'b0011;
    tick(1);
    chk("wd_gnt0", wd_gnt, 4'b0001);
    chk("wd_send0", wd_tx_send, 1);
    tick(16);
    chk("wd_no_timeout_yet", wd_timeout, 0);
    chk("wd_busy_wait", wd_busy, 1);
    tick(1);
    chk("wd_timeout", wd_timeout, 1);
    chk("wd_busy_abort", wd_busy, 0);
    tick(1);
    chk("wd_gnt1", wd_gnt, 4'b0010);
    chk("wd_owner1", wd_owner, 1);
    chk("wd_timeout_once", wd_timeout, 0);
    wd_req = '0;
    // tx_done arriving in the expiry cycle wins over the watchdog
    tick(16);
    wd_done = 1'b1;
    tick(1);
    wd_done = 1'b0;
    chk("wd_done_wins", wd_timeout, 0);
    chk("wd_gap_busy", wd_busy, 1);
    tick(2);
    chk("wd_gap_end", wd_busy, 0);
    chk("wd_no_regrant", wd_gnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
